// File: rtl/output_deskew_aligner.sv
// Realigns lane-staggered result beats into parallel words: lane k is delayed
// LANES-1-k accepted beats, and aligned words are queued in a 2-entry output buffer.
module output_deskew_aligner #(
  parameter int LANES = 4,
  parameter int W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               out_last
);

  localparam int CW = $clog2(LANES);
  localparam int FW = LANES*W + 1;

  typedef enum logic {S_FILL, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     mem_q [2];
  logic [FW-1:0]     mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              accept, push, pop, shift_en;
  logic [LANES*W-1:0] aligned;

  assign in_ready = !rst && ((count_q < 2'd2) || (count_q == 2'd2 && out_ready));
  assign accept   = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop      = out_valid && out_ready;
  assign {out_last, out_data} = mem_q[rd_ptr_q];

  // The aligned word is taken from the oldest stage before this beat shifts in.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int D = LANES - 1 - gi;
    if (D == 0) begin : g_pass
      assign aligned[gi*W +: W] = in_data[gi*W +: W];
    end else begin : g_dly
      logic [W-1:0] dly_q [D];
      logic [W-1:0] dly_d [D];

      always_comb begin
        dly_d = dly_q;
        if (shift_en) begin
          dly_d[0] = in_data[gi*W +: W];
          for (int j = 1; j < D; j++) dly_d[j] = dly_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < D; j++) dly_q[j] <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign aligned[gi*W +: W] = dly_q[D-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    shift_en = 1'b0;
    if (accept) begin
      case (state_q)
        S_FILL: begin
          // A last beat before the lanes are full is a short stream: drop it.
          if (in_last) begin
            cnt_d = '0;
          end else begin
            shift_en = 1'b1;
            if (cnt_q == CW'(LANES-2)) begin
              cnt_d   = '0;
              state_d = S_STREAM;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          shift_en = 1'b1;
          push     = 1'b1;
          if (in_last) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push) mem_d[wr_ptr_q] = {in_last, aligned};
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
